// File: rtl/core_v_mcu_reg_pkg.sv
// Register-bus request/response types shared by the MCU peripherals.
package core_v_mcu_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_resp_t;

endpackage

// File: rtl/machine_timer.sv
// machine_timer: 64-bit machine timer (mtime/mtimecmp) with a 16-bit
// prescaler, a level interrupt (mtime >= mtimecmp), a tick pulse and a
// zero-wait-state register-bus slave. The MTIME_HI read path goes through
// a shadow captured on MTIME_LO reads so a LO-then-HI read pair is coherent.
module machine_timer #(
    parameter type reg_req_t = core_v_mcu_reg_pkg::reg_req_t,
    parameter type reg_rsp_t = core_v_mcu_reg_pkg::reg_resp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     time_irq_o,
    output logic     tick_o
);

    // Word index of each register (addr[4:2]); indices 6 and 7 are unmapped.
    localparam logic [2:0] IDX_MTIME_LO    = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI    = 3'd1;
    localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] IDX_CTRL        = 3'd4;
    localparam logic [2:0] IDX_PRESCALE    = 3'd5;

    // Architectural state
    logic [63:0] mtime_reg,    mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic [31:0] shadow_reg,   shadow_next;
    logic [15:0] pcnt_reg,     pcnt_next;
    logic [15:0] prescale_reg, prescale_next;
    logic        en_reg,       en_next;
    logic        tick_reg;
    logic        irq_reg,      irq_next;

    // Bus decode
    logic [2:0]  reg_idx;
    logic        addr_err;
    logic        acc_ok;
    logic        wr_en;
    logic        rd_en;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        rd_mtime_lo;
    logic [31:0] wr_mask;

    // Prescaler / increment control
    logic        tick_raw;
    logic        tick_inc;

    // Only addr[4:2] selects a register; the rest of the address is ignored.
    logic        unused_addr;
    assign unused_addr = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0]};

    // Merge written bytes into an existing word under the byte-lane mask.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign reg_idx  = reg_req_i.addr[4:2];
    assign addr_err = reg_idx[2] & reg_idx[1];
    assign acc_ok   = reg_req_i.valid & ~addr_err;
    assign wr_en    = acc_ok & reg_req_i.write;
    assign rd_en    = acc_ok & ~reg_req_i.write;

    assign wr_mtime_lo = wr_en && (reg_idx == IDX_MTIME_LO);
    assign wr_mtime_hi = wr_en && (reg_idx == IDX_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (reg_idx == IDX_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (reg_idx == IDX_MTIMECMP_HI);
    assign wr_ctrl     = wr_en && (reg_idx == IDX_CTRL);
    assign wr_prescale = wr_en && (reg_idx == IDX_PRESCALE);
    assign rd_mtime_lo = rd_en && (reg_idx == IDX_MTIME_LO);

    // Expand each strobe bit into a full byte lane mask.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign wr_mask[gi*8 +: 8] = {8{reg_req_i.wstrb[gi]}};
        end
    endgenerate

    // A prescaler match produces a tick unless PRESCALE is being rewritten;
    // a software write to mtime in the same cycle takes priority over it.
    assign tick_raw = en_reg && (pcnt_reg == prescale_reg) && !wr_prescale;
    assign tick_inc = tick_raw && !(wr_mtime_lo || wr_mtime_hi);

    // Prescaler counter: restart on PRESCALE write or EN falling, else count and wrap.
    always_comb begin
        pcnt_next = pcnt_reg;
        if (wr_prescale) begin
            pcnt_next = '0;
        end else if (wr_ctrl && reg_req_i.wstrb[0] && !reg_req_i.wdata[0] && en_reg) begin
            pcnt_next = '0;
        end else if (en_reg) begin
            pcnt_next = (pcnt_reg == prescale_reg) ? 16'd0 : pcnt_reg + 16'd1;
        end
    end

    // mtime: software writes win over the increment for that cycle.
    always_comb begin
        mtime_next = mtime_reg;
        if (wr_mtime_lo) begin
            mtime_next[31:0] = merge_bytes(mtime_reg[31:0], reg_req_i.wdata, wr_mask);
        end else if (wr_mtime_hi) begin
            mtime_next[63:32] = merge_bytes(mtime_reg[63:32], reg_req_i.wdata, wr_mask);
        end else if (tick_inc) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    // Shadow of mtime[63:32]: snapshot on LO read, written bytes on HI write.
    always_comb begin
        shadow_next = shadow_reg;
        if (rd_mtime_lo) begin
            shadow_next = mtime_reg[63:32];
        end else if (wr_mtime_hi) begin
            shadow_next = merge_bytes(shadow_reg, reg_req_i.wdata, wr_mask);
        end
    end

    // Compare value and control registers: plain byte-masked writes.
    always_comb begin
        mtimecmp_next = mtimecmp_reg;
        en_next       = en_reg;
        prescale_next = prescale_reg;
        if (wr_cmp_lo) begin
            mtimecmp_next[31:0] = merge_bytes(mtimecmp_reg[31:0], reg_req_i.wdata, wr_mask);
        end
        if (wr_cmp_hi) begin
            mtimecmp_next[63:32] = merge_bytes(mtimecmp_reg[63:32], reg_req_i.wdata, wr_mask);
        end
        if (wr_ctrl && reg_req_i.wstrb[0]) begin
            en_next = reg_req_i.wdata[0];
        end
        if (wr_prescale) begin
            prescale_next[7:0] = reg_req_i.wstrb[0] ? reg_req_i.wdata[7:0] : prescale_reg[7:0];
            prescale_next[15:8] = reg_req_i.wstrb[1] ? reg_req_i.wdata[15:8] : prescale_reg[15:8];
        end
    end

    // Interrupt follows the post-update comparison so it tracks writes immediately.
    assign irq_next = (mtime_next >= mtimecmp_next);

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_reg   <= '0;
            pcnt_reg     <= '0;
            prescale_reg <= '0;
            en_reg       <= 1'b0;
            tick_reg     <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            shadow_reg   <= shadow_next;
            pcnt_reg     <= pcnt_next;
            prescale_reg <= prescale_next;
            en_reg       <= en_next;
            tick_reg     <= tick_inc;
            irq_reg      <= irq_next;
        end
    end

    // Zero-wait-state response: ready mirrors valid, read data muxed combinationally.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        reg_rsp_o.error = reg_req_i.valid & addr_err;
        if (rd_en) begin
            case (reg_idx)
                IDX_MTIME_LO:    reg_rsp_o.rdata = mtime_reg[31:0];
                IDX_MTIME_HI:    reg_rsp_o.rdata = shadow_reg;
                IDX_MTIMECMP_LO: reg_rsp_o.rdata = mtimecmp_reg[31:0];
                IDX_MTIMECMP_HI: reg_rsp_o.rdata = mtimecmp_reg[63:32];
                IDX_CTRL:        reg_rsp_o.rdata = {31'd0, en_reg};
                IDX_PRESCALE:    reg_rsp_o.rdata = {16'd0, prescale_reg};
                default:         reg_rsp_o.rdata = '0;
            endcase
        end
    end

    assign tick_o     = tick_reg;
    assign time_irq_o = irq_reg;

endmodule

// File: tb/tb_machine_timer.sv
// Directed testbench for machine_timer: bus accesses via small tasks,
// expected values computed by hand against the cycle-level behaviour.
module tb_machine_timer;
    import core_v_mcu_reg_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_req_t  req;
    reg_resp_t rsp;
    reg_resp_t last_rsp;
    logic      irq;
    logic      tick;
    logic [31:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    machine_timer #(
        .reg_req_t(reg_req_t),
        .reg_rsp_t(reg_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .reg_req_i  (req),
        .reg_rsp_o  (rsp),
        .time_irq_o (irq),
        .tick_o     (tick)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; commits on the next rising edge, returns at the following falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        req.addr  = addr;
        req.write = 1'b1;
        req.wdata = data;
        req.wstrb = strb;
        req.valid = 1'b1;
        #1;
        last_rsp = rsp;
        $display("wr addr=0x%02h data=0x%08h strb=%b ready=%0b error=%0b rdata=0x%08h",
                 addr, data, strb, rsp.ready, rsp.error, rsp.rdata);
        @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        req.addr  = addr;
        req.write = 1'b0;
        req.wdata = '0;
        req.wstrb = '0;
        req.valid = 1'b1;
        #1;
        last_rsp = rsp;
        data     = rsp.rdata;
        $display("rd addr=0x%02h rdata=0x%08h ready=%0b error=%0b", addr, rsp.rdata, rsp.ready, rsp.error);
        @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);

        // Reset values, bus alive during reset
        check("rst_tick", tick, 1'b0);
        check("rst_irq", irq, 1'b0);
        bus_read(32'h08, rd);
        check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        check("rst_ready", last_rsp.ready, 1'b1);
        rst_n = 1'b1;
        bus_read(32'h00, rd); check("rst_mtime_lo", rd, 32'h0);
        bus_read(32'h04, rd); check("rst_mtime_hi", rd, 32'h0);
        bus_read(32'h0C, rd); check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        bus_read(32'h10, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(32'h14, rd); check("rst_prescale", rd, 32'h0);
        #1;
        check("idle_ready", rsp.ready, 1'b0);
        check("idle_rdata", rsp.rdata, 32'h0);

        // PRESCALE=3, cmp=5: tick every 4th cycle, irq with mtime reaching 5
        bus_write(32'h14, 32'd3, 4'hF);
        check("wr_rdata_zero", last_rsp.rdata, 32'h0);
        check("wr_error", last_rsp.error, 1'b0);
        bus_write(32'h08, 32'd5, 4'hF);
        bus_write(32'h0C, 32'd0, 4'hF);
        check("irq_low_cmp5", irq, 1'b0);
        bus_write(32'h10, 32'd1, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("p3_tick_c%0d", k), tick, (k % 4) == 0);
            check($sformatf("p3_irq_c%0d", k), irq, k >= 20);
        end
        bus_read(32'h00, rd); check("p3_mtime_lo", rd, 32'd5);
        bus_write(32'h10, 32'd0, 4'hF);
        check("irq_with_en0", irq, 1'b1);
        bus_read(32'h04, rd); check("p3_shadow_hi", rd, 32'd0);
        bus_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
        check("irq_clr_cmp_hi", irq, 1'b0);

        // LO->HI carry and coherent HI read through the shadow
        bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h04, 32'h0, 4'hF);
        bus_write(32'h14, 32'h0, 4'hF);
        bus_write(32'h10, 32'd1, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("carry_tick", tick, 1'b1);
        bus_read(32'h00, rd); check("carry_lo", rd, 32'h0);
        bus_read(32'h04, rd); check("carry_hi_shadow", rd, 32'h1);
        bus_write(32'h10, 32'd0, 4'hF);

        // 64-bit wrap; HI write also updates the shadow
        bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h04, 32'hFFFF_FFFF, 4'hF);
        check("irq_all_ones", irq, 1'b1);
        bus_read(32'h04, rd); check("shadow_hi_write", rd, 32'hFFFF_FFFF);
        bus_write(32'h10, 32'd1, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("wrap_tick", tick, 1'b1);
        check("wrap_irq", irq, 1'b0);
        bus_read(32'h00, rd); check("wrap_lo", rd, 32'h0);
        bus_read(32'h04, rd); check("wrap_hi", rd, 32'h0);
        bus_write(32'h10, 32'd0, 4'hF);

        // Partial mtime write colliding with a tick: write wins, no increment
        bus_write(32'h00, 32'hAAAA_BBBB, 4'hF);
        bus_write(32'h04, 32'h0, 4'hF);
        bus_write(32'h10, 32'd1, 4'hF);
        bus_write(32'h00, 32'h1234_5678, 4'b0011);
        check("collide_tick", tick, 1'b0);
        bus_read(32'h00, rd); check("collide_lo", rd, 32'hAAAA_5678);
        check("collide_tick_next", tick, 1'b1);
        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h00, 32'h0, 4'b0000);
        check("strb0_ready", last_rsp.ready, 1'b1);
        bus_read(32'h00, rd); check("strb0_lo", rd, 32'hAAAA_567A);

        // Unmapped offsets
        bus_read(32'h18, rd);
        check("unmap_rdata", rd, 32'h0);
        check("unmap_error", last_rsp.error, 1'b1);
        check("unmap_ready", last_rsp.ready, 1'b1);
        bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
        check("unmap_wr_error", last_rsp.error, 1'b1);
        bus_read(32'h10, rd); check("unmap_ctrl", rd, 32'h0);
        bus_read(32'h14, rd); check("unmap_prescale", rd, 32'h0);
        bus_read(32'h00, rd); check("unmap_mtime", rd, 32'hAAAA_567A);

        // Reserved bits read as zero
        bus_write(32'h14, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h14, rd); check("prescale_raz", rd, 32'h0000_FFFF);
        bus_write(32'h14, 32'h0, 4'hF);
        bus_write(32'h10, 32'hFFFF_FFFE, 4'hF);
        bus_read(32'h10, rd); check("ctrl_raz", rd, 32'h0);

        // PRESCALE write suppresses the tick of that cycle
        bus_write(32'h10, 32'd1, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("ps_tick_before", tick, 1'b1);
        bus_write(32'h14, 32'h0, 4'hF);
        check("ps_tick_suppressed", tick, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("ps_tick_resume", tick, 1'b1);

        // Asynchronous reset mid-count
        bus_write(32'h08, 32'h0, 4'hF);
        bus_write(32'h0C, 32'h0, 4'hF);
        check("pre_rst_irq", irq, 1'b1);
        check("pre_rst_tick", tick, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tick", tick, 1'b0);
        check("async_rst_irq", irq, 1'b0);
        req.addr = 32'h08; req.write = 1'b0; req.wstrb = 4'h0; req.wdata = '0; req.valid = 1'b1;
        #1;
        check("async_rst_cmp", rsp.rdata, 32'hFFFF_FFFF);
        check("async_rst_ready", rsp.ready, 1'b1);
        req.addr = 32'h00;
        #1;
        check("async_rst_mtime", rsp.rdata, 32'h0);
        req.addr = 32'h10; req.write = 1'b1; req.wdata = 32'd1; req.wstrb = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0; req.write = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_tick", tick, 1'b0);
        bus_read(32'h10, rd); check("post_rst_ctrl", rd, 32'h0);
        bus_read(32'h00, rd); check("post_rst_mtime", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
